uart_rx: RTL and testbench

Serial UART receiver, 8N1 framing, LSB first. It samples the `rx` line on the 8×-baud strobe `baud8_tick` from the UART baud-rate generator and delivers each received byte to the core-side UART peripheral as a one-cycle `rx_valid` pulse. It is the receive counterpart of the UART transmit path and shares that path's baud generator.

---
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling rx on an 8x-baud tick; LSB first, one-cycle valid/frame-error pulses.
// Optional build macro UART_RX_MAJORITY_EN: 3-sample majority vote on rx instead of a single sample.
module uart_rx #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud8_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 smp;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Two previous tick samples; the newest history entry is rx_s itself
  logic [1:0] hist_q, hist_d;
  logic [2:0] hist_now;

  always_comb begin
    hist_now = {hist_q, rx_s_q};
    hist_d   = baud8_tick ? hist_now[1:0] : hist_q;
    smp      = (hist_now[0] & hist_now[1]) | (hist_now[0] & hist_now[2]) |
               (hist_now[1] & hist_now[2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end
`else
  assign smp = rx_s_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Frame sequencing; all state and counters advance only on baud8_tick
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (baud8_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!smp) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end
        S_START: begin
          tick_cnt_d = CNT_W'(tick_cnt_q + CNT_W'(1));
          if (tick_cnt_q == CNT_W'(2)) begin
            if (smp) begin
              state_d = S_IDLE;
            end else begin
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_idx_d  = '0;
            end
          end
        end
        S_DATA: begin
          tick_cnt_d = CNT_W'(tick_cnt_q + CNT_W'(1));
          if (tick_cnt_q == CNT_W'(7)) begin
            shift_d = {smp, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == IDX_W'(DATA_BITS - 1)) state_d = S_STOP;
            else bit_idx_d = IDX_W'(bit_idx_q + IDX_W'(1));
          end
        end
        S_STOP: begin
          tick_cnt_d = CNT_W'(tick_cnt_q + CNT_W'(1));
          // Leave at mid-stop-bit so an immediately following start bit is caught
          if (tick_cnt_q == CNT_W'(7)) begin
            state_d = S_IDLE;
            if (smp) begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are built tick-by-tick from bytes,
// expected results are queued, and a monitor pops them on every output pulse.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud8_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       exp_e;
  int         n_vec = 0;
  int         n_err = 0;
  bit         fixed_gap = 1'b1;
  logic [7:0] last_good;
  logic [7:0] rnd;
  logic [7:0] glitch_exp;
  logic [7:0] f0 = 8'hF0;

  uart_rx #(.DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .baud8_tick(baud8_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // Tick generator: fixed 4-clk spacing, or random 1..4 (including back-to-back ticks)
  initial begin
    int g;
    forever begin
      g = fixed_gap ? 4 : int'($urandom_range(1, 4));
      baud8_tick = 1'b1;
      @(negedge clk);
      baud8_tick = 1'b0;
      repeat (g - 1) @(negedge clk);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (baud8_tick !== 1'b1);
    #1;
  endtask

  // One slot = the rx level held for one baud8 tick period
  task automatic slot(input logic v);
    rx = v;
    wait_tick();
  endtask

  // Frame of 8 ticks per bit; glitch_bit >= 0 forces a 1-tick high at that bit's sample point
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int glitch_bit,
                            input logic [7:0] exp_d);
    exp_t e;
    if (stop_ok) begin
      e.err = 1'b0; e.data = exp_d; last_good = exp_d;
    end else begin
      e.err = 1'b1; e.data = last_good;
    end
    exp_q.push_back(e);
    repeat (8) slot(1'b0);
    for (int k = 0; k < 8; k++)
      for (int s = 0; s < 8; s++)
        slot((k == glitch_bit && s == 3) ? 1'b1 : d[k]);
    if (stop_ok) repeat (8) slot(1'b1);
    else begin
      repeat (4) slot(1'b0);
      slot(1'b1);
    end
  endtask

  // Scoreboard monitor: every output pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_frame_err) check("valid_err_same_cycle", 32'(1), 32'(0));
      else if (rx_valid || rx_frame_err) begin
        if (exp_q.size() == 0) check("unexpected_pulse", 32'({rx_valid, rx_frame_err}), 32'(0));
        else begin
          exp_e = exp_q.pop_front();
          check("pulse_kind", 32'({rx_valid, rx_frame_err}), 32'({~exp_e.err, exp_e.err}));
          check("rx_data", 32'(rx_data), 32'(exp_e.data));
        end
      end
    end
  end

  initial begin
    last_good = 8'h00;
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h04;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'(0));
    check("reset_rx_valid", 32'(rx_valid), 32'(0));
    check("reset_rx_frame_err", 32'(rx_frame_err), 32'(0));
    check("reset_rx_busy", 32'(rx_busy), 32'(0));
    rst = 1'b0;
    repeat (5) slot(1'b1);

    send_frame(8'h55, 1'b1, -1, 8'h55);
    repeat (3) slot(1'b1);
    check("busy_after_55", 32'(rx_busy), 32'(0));

    send_frame(8'h3C, 1'b1, -1, 8'h3C);
    repeat (3) slot(1'b1);
    send_frame(8'hA5, 1'b0, -1, 8'hA5);
    repeat (6) slot(1'b1);
    check("busy_after_ferr", 32'(rx_busy), 32'(0));
    check("data_held_after_ferr", 32'(rx_data), 32'(8'h3C));

    // False start: two low ticks, then high
    repeat (2) slot(1'b0);
    check("busy_during_false_start", 32'(rx_busy), 32'(1));
    repeat (4) slot(1'b1);
    check("busy_after_false_start", 32'(rx_busy), 32'(0));
    send_frame(8'h81, 1'b1, -1, 8'h81);
    repeat (3) slot(1'b1);

    // Irregular tick spacing, back-to-back frames, then random bytes
    fixed_gap = 1'b0;
    repeat (4) slot(1'b1);
    send_frame(8'h00, 1'b1, -1, 8'h00);
    send_frame(8'hFF, 1'b1, -1, 8'hFF);
    for (int i = 0; i < 12; i++) begin
      rnd = 8'($urandom);
      send_frame(rnd, 1'b1, -1, rnd);
      repeat ($urandom_range(0, 3)) slot(1'b1);
    end
    fixed_gap = 1'b1;
    repeat (6) slot(1'b1);

    // Reset after bit 3 of 0xF0
    repeat (8) slot(1'b0);
    for (int k = 0; k < 4; k++) repeat (8) slot(f0[k]);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check("midreset_rx_data", 32'(rx_data), 32'(0));
    check("midreset_rx_busy", 32'(rx_busy), 32'(0));
    check("midreset_pulses", 32'({rx_valid, rx_frame_err}), 32'(0));
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) slot(1'b1);
    send_frame(8'h12, 1'b1, -1, 8'h12);
    repeat (3) slot(1'b1);
    check("data_after_reset_frame", 32'(rx_data), 32'(8'h12));

    send_frame(8'h00, 1'b1, 2, glitch_exp);
    repeat (10) slot(1'b1);
    check("all_expected_seen", 32'(exp_q.size()), 32'(0));
    check("busy_at_end", 32'(rx_busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
